// File: rtl/ip_hdr_word_decode_pkg.sv
// Shared encodings and protocol constants for the IPv4 header-word tracker.
// Imported by the tracker and by any sibling preprocess stage that needs them.
package ip_hdr_word_decode_pkg;

    typedef enum logic [1:0] {
        MOD_HDRS = 2'd0,
        IN_HDR   = 2'd1,
        PAYLOAD  = 2'd2
    } state_t;

    localparam logic [2:0] WORD_DA_SA_HI   = 3'd0;
    localparam logic [2:0] WORD_SA_LO_ETH  = 3'd1;
    localparam logic [2:0] WORD_LEN_ID_TTL = 3'd2;
    localparam logic [2:0] WORD_SRC_DST    = 3'd3;
    localparam logic [2:0] WORD_DST_LO     = 3'd4;

    localparam logic [15:0] ETHERTYPE_IP = 16'h0800;
    localparam logic [3:0]  IP_VERSION_4 = 4'd4;
    localparam logic [3:0]  IHL_NO_OPTS  = 4'd5;

endpackage

// File: rtl/ip_hdr_word_decode.sv
// Tracks which Ethernet/IPv4 header word is on in_data (zero-latency strobes)
// and registers per-packet IPv4 flags plus header-done / EOP / runt pulses.
module ip_hdr_word_decode
    import ip_hdr_word_decode_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  word_MAC_DA_SA_HI,
    output logic                  word_MAC_SA_LO_ETH,
    output logic                  word_IP_LEN_ID_TTL,
    output logic                  word_IP_SRC_DST,
    output logic                  word_IP_DST_LO,
    output logic                  is_ipv4,
    output logic [3:0]            ip_hdr_len,
    output logic                  ip_has_opts,
    output logic                  hdr_done,
    output logic                  pkt_eop,
    output logic                  runt_err
);

    state_t     state, state_nxt;
    logic [2:0] idx, idx_nxt;
    logic [4:0] strobe;
    logic       is_data;
    logic       capture, done_nxt, eop_nxt, runt_nxt;

    // Upper data bytes are consumed by sibling stages, not here.
    logic unused_data;
    assign unused_data = ^in_data[DATA_WIDTH-1:32];

    assign is_data = (in_ctrl == '0);

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        strobe    = '0;
        capture   = 1'b0;
        done_nxt  = 1'b0;
        eop_nxt   = 1'b0;
        runt_nxt  = 1'b0;
        // Reset gates the Mealy strobes so nothing leaks out while the pipeline is held.
        if (in_wr && !reset) begin
            case (state)
                MOD_HDRS: begin
                    if (is_data) begin
                        strobe[WORD_DA_SA_HI] = 1'b1;
                        state_nxt = IN_HDR;
                        idx_nxt   = WORD_SA_LO_ETH;
                    end
                end
                IN_HDR: begin
                    case (idx)
                        WORD_SA_LO_ETH:  strobe[WORD_SA_LO_ETH]  = 1'b1;
                        WORD_LEN_ID_TTL: strobe[WORD_LEN_ID_TTL] = 1'b1;
                        WORD_SRC_DST:    strobe[WORD_SRC_DST]    = 1'b1;
                        WORD_DST_LO:     strobe[WORD_DST_LO]     = 1'b1;
                        default:         strobe                  = '0;
                    endcase
                    capture  = (idx == WORD_SA_LO_ETH);
                    done_nxt = (idx == WORD_DST_LO);
                    if (!is_data) begin
                        eop_nxt   = 1'b1;
                        runt_nxt  = (idx != WORD_DST_LO);
                        state_nxt = MOD_HDRS;
                        idx_nxt   = '0;
                    end else if (idx == WORD_DST_LO) begin
                        state_nxt = PAYLOAD;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx + 3'd1;
                    end
                end
                PAYLOAD: begin
                    if (!is_data) begin
                        eop_nxt   = 1'b1;
                        state_nxt = MOD_HDRS;
                    end
                end
                default: begin
                    state_nxt = MOD_HDRS;
                    idx_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= MOD_HDRS;
            idx         <= '0;
            is_ipv4     <= 1'b0;
            ip_hdr_len  <= '0;
            ip_has_opts <= 1'b0;
            hdr_done    <= 1'b0;
            pkt_eop     <= 1'b0;
            runt_err    <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            hdr_done <= done_nxt;
            pkt_eop  <= eop_nxt;
            runt_err <= runt_nxt;
            if (capture) begin
                is_ipv4     <= (in_data[31:16] == ETHERTYPE_IP) && (in_data[15:12] == IP_VERSION_4);
                ip_hdr_len  <= in_data[11:8];
                ip_has_opts <= (in_data[11:8] != IHL_NO_OPTS);
            end
        end
    end

    assign word_MAC_DA_SA_HI  = strobe[WORD_DA_SA_HI];
    assign word_MAC_SA_LO_ETH = strobe[WORD_SA_LO_ETH];
    assign word_IP_LEN_ID_TTL = strobe[WORD_LEN_ID_TTL];
    assign word_IP_SRC_DST    = strobe[WORD_SRC_DST];
    assign word_IP_DST_LO     = strobe[WORD_DST_LO];

endmodule

// File: doc/ip_hdr_word_decode.md
Name: ip_hdr_word_decode

Overview:
- Packet-word tracker in the router's preprocess stage, placed directly upstream of the LPM lookup stage and its sibling header-parsing stages.
- Snoops the 64-bit module-header/data stream without flow control. It raises zero-latency one-hot strobes that mark which Ethernet/IPv4 header word is on in_data.
- Also produces registered per-packet flags (IPv4 check, IHL, runt, end-of-packet) for downstream stages.

Parameters:
- DATA_WIDTH, 64, datapath width; only 64 is supported.
- CTRL_WIDTH, DATA_WIDTH/8, control-byte width.

Ports:
- clk  input  1  single clock.
- reset  input  1  synchronous, active-high.
- in_data  input  DATA_WIDTH  stream data word.
- in_ctrl  input  CTRL_WIDTH  nonzero = module header (before data) or EOP marker (after data).
- in_wr  input  1  word valid this cycle.
- word_MAC_DA_SA_HI  output  1  strobe: data word 0 (DA[47:0], SA[47:32]).
- word_MAC_SA_LO_ETH  output  1  strobe: data word 1 (SA[31:0], ethertype, ver/IHL/TOS).
- word_IP_LEN_ID_TTL  output  1  strobe: data word 2 (len, ID, flags/frag, TTL, proto).
- word_IP_SRC_DST  output  1  strobe: data word 3 (cksum, src IP, dst IP[31:16] in in_data[15:0]).
- word_IP_DST_LO  output  1  strobe: data word 4 (dst IP[15:0] in in_data[63:48]).
- is_ipv4  output  1  registered: last word 1 had ethertype 0x0800 and version 4.
- ip_hdr_len  output  4  registered: IHL captured from word 1.
- ip_has_opts  output  1  registered: captured IHL != 5.
- hdr_done  output  1  one-cycle pulse, the cycle after word_IP_DST_LO.
- pkt_eop  output  1  one-cycle pulse, the cycle after the EOP word.
- runt_err  output  1  one-cycle pulse, the cycle after an EOP that arrives before data word 4.

Behaviour:
- State machine states:
  - MOD_HDRS: reset state.
  - IN_HDR: 3-bit word index 1..4.
  - PAYLOAD.
- Transitions, evaluated only when in_wr=1; with in_wr=0, state, index and all strobes are held/low:
  - MOD_HDRS, in_ctrl!=0: stay (module header); no strobe.
  - MOD_HDRS, in_ctrl==0: this word is data word 0; assert word_MAC_DA_SA_HI; go to IN_HDR, index=1.
  - IN_HDR, index k: assert the strobe for word k.
    - in_ctrl==0, k<4: index=k+1.
    - in_ctrl==0, k=4: go to PAYLOAD.
    - in_ctrl!=0: EOP; go to MOD_HDRS. The strobe still fires (the word carries valid bytes).
  - PAYLOAD, in_ctrl!=0: EOP; go to MOD_HDRS. in_ctrl==0: stay.
- Strobe timing:
  - Strobes are Mealy outputs: asserted in the same cycle the word is on in_data with in_wr=1, qualified by in_wr.
  - Exactly one strobe is high per header word. All strobes are low in MOD_HDRS (except word 0) and in PAYLOAD.
- Registered outputs:
  - is_ipv4, ip_hdr_len and ip_has_opts update on the clock edge ending the word-1 strobe cycle. They hold until the next packet's word 1.
  - is_ipv4 = (in_data[31:16]==16'h0800) && (in_data[15:12]==4).
  - ip_hdr_len = in_data[11:8].
- EOP handling:
  - pkt_eop pulses one cycle after any EOP word, in either IN_HDR or PAYLOAD.
  - runt_err pulses with pkt_eop only when EOP occurs at index 1..3.
  - EOP at index 4: pkt_eop only, no runt_err. hdr_done still pulses.
- Back-to-back packets: an EOP word followed by the next packet's module header in the next cycle needs no idle cycle.
- Reset:
  - Values: state MOD_HDRS, index 0, is_ipv4=0, ip_hdr_len=0, ip_has_opts=0, hdr_done=0, pkt_eop=0, runt_err=0, strobes low.
  - Reset mid-packet abandons the packet and emits no pulses. The pipeline resets all stages together, so the next word is treated from MOD_HDRS.

Decomposition:
- Shared package holds:
  - state encoding (MOD_HDRS, IN_HDR, PAYLOAD);
  - word-index constants WORD_DA_SA_HI=0 .. WORD_DST_LO=4;
  - ETHERTYPE_IP=16'h0800, IP_VERSION_4=4, IHL_NO_OPTS=5.
- No sub-module: the index counter and state machine live in one block.

Test Plan:
- 1 module header (ctrl 0xFF), 7 data words (dst 10.0.1.2), EOP ctrl 0x08 -> strobes high on data words 0..4 in order, one per cycle; in_data[15:0]=16'h0A00 at word_IP_SRC_DST; in_data[63:48]=16'h0102 at word_IP_DST_LO; hdr_done 1 cycle after word 4; pkt_eop 1 cycle after EOP; is_ipv4=1, ip_hdr_len=5, ip_has_opts=0.
- Same packet with in_wr low for 3 cycles between words 2 and 3 -> no strobes during gaps; word_IP_SRC_DST fires on the next in_wr word; no duplicates.
- EOP (ctrl 0x40) on data word 2 -> word_IP_LEN_ID_TTL fires; runt_err and pkt_eop pulse next cycle; hdr_done never pulses; next packet decodes normally.
- Ethertype 0x0806 packet, then IPv4 packet with IHL=6 -> is_ipv4=0 after first word 1; then is_ipv4=1, ip_hdr_len=6, ip_has_opts=1.
- Two packets back-to-back with no idle (EOP then module header next cycle) -> both decode with correct strobes; two pkt_eop pulses.
- Reset asserted during payload, then a fresh packet -> all outputs 0 during reset; fresh packet strobes correct; no stale pkt_eop.
